// File: rtl/control_unit.sv
// control_unit: hardwired T-step sequencer for the CPU datapath; define MULDIV_EN to add the mul/div sequence and WAIT_ALU.
module control_unit #(
  parameter int CTL_W = 41,
  parameter int OP_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  ir_op,
  input  logic             do_branch,
  input  logic             alu_done,
  input  logic             stop,
  input  logic             run,
  output logic [CTL_W-1:0] ctl,
  output logic             halted,
  output logic             illegal,
  output logic             instr_done
);
  localparam int PCOUT = 0, PCIN = 1, INCPC = 2, MARIN = 3, READ = 4, MDRIN = 5, MDROUT = 6, IRIN = 7;
  localparam int ZIN = 8, ZLOWOUT = 9, ZHIGHOUT = 10, YIN = 11, GRA = 12, GRB = 13, GRC = 14, RIN = 15;
  localparam int ROUT = 16, BAOUT = 17, COUT = 18, WRITE = 19, LOIN = 20, LOOUT = 21, HIIN = 22, HIOUT = 23;
  localparam int CONIN = 24, BRANCH = 25, OUTIN = 26, INOUT = 27, START = 28, ALU_LO = 29;
  typedef enum logic [3:0] {
    RST, T0, T1, T2, T3, T4, T5, T6, T7,
`ifdef MULDIV_EN
    WAIT_ALU,
`endif
    HALT
  } state_t;
  state_t state, nxt;
  logic [4:0] op;
  logic [11:0] alu;
  logic [40:0] c;
  logic last;
  assign op = 5'(ir_op);
  // one-hot ALU function: ADD,SUB,MUL,DIV,SHR,SHL,ROR,ROL,AND,OR,NEG,NOT
  always_comb begin
    alu = '0;
    case (op)
      5'd3, 5'd11: alu[0] = 1'b1;
      5'd4:        alu[1] = 1'b1;
      5'd14:       alu[2] = 1'b1;
      5'd15:       alu[3] = 1'b1;
      5'd7:        alu[4] = 1'b1;
      5'd8:        alu[5] = 1'b1;
      5'd9:        alu[6] = 1'b1;
      5'd10:       alu[7] = 1'b1;
      5'd5, 5'd12: alu[8] = 1'b1;
      5'd6, 5'd13: alu[9] = 1'b1;
      5'd16:       alu[10] = 1'b1;
      5'd17:       alu[11] = 1'b1;
      default:     alu = '0;
    endcase
  end
  always_comb begin
    c = '0;
    nxt = T0;
    last = 1'b0;
    illegal = 1'b0;
    halted = 1'b0;
    case (state)
      T0: begin c[PCOUT] = 1'b1; c[MARIN] = 1'b1; c[INCPC] = 1'b1; c[ZIN] = 1'b1; nxt = T1; end
      T1: begin c[ZLOWOUT] = 1'b1; c[PCIN] = 1'b1; c[READ] = 1'b1; c[MDRIN] = 1'b1; nxt = T2; end
      T2: begin c[MDROUT] = 1'b1; c[IRIN] = 1'b1; nxt = T3; end
      T3: begin
        nxt = T4;
        case (op) inside
          [5'd0:5'd2]:  begin c[GRB] = 1'b1; c[BAOUT] = 1'b1; c[YIN] = 1'b1; end
          [5'd3:5'd13]: begin c[GRB] = 1'b1; c[ROUT] = 1'b1; c[YIN] = 1'b1; end
`ifdef MULDIV_EN
          5'd14, 5'd15: begin c[GRA] = 1'b1; c[ROUT] = 1'b1; c[YIN] = 1'b1; end
`endif
          5'd16, 5'd17: begin c[GRB] = 1'b1; c[ROUT] = 1'b1; c[ZIN] = 1'b1; c[40:ALU_LO] = alu; end
          5'd18: begin c[GRA] = 1'b1; c[ROUT] = 1'b1; c[CONIN] = 1'b1; end
          5'd19: begin c[GRA] = 1'b1; c[ROUT] = 1'b1; c[PCIN] = 1'b1; last = 1'b1; end
          5'd21: begin c[INOUT] = 1'b1; c[GRA] = 1'b1; c[RIN] = 1'b1; last = 1'b1; end
          5'd22: begin c[GRA] = 1'b1; c[ROUT] = 1'b1; c[OUTIN] = 1'b1; last = 1'b1; end
          5'd23: begin c[HIOUT] = 1'b1; c[GRA] = 1'b1; c[RIN] = 1'b1; last = 1'b1; end
          5'd24: begin c[LOOUT] = 1'b1; c[GRA] = 1'b1; c[RIN] = 1'b1; last = 1'b1; end
          5'd25, 5'd26: last = 1'b1;
          default: begin illegal = 1'b1; last = 1'b1; end
        endcase
      end
      T4: begin
        nxt = T5;
        case (op) inside
          [5'd0:5'd2]:   begin c[COUT] = 1'b1; c[ALU_LO] = 1'b1; c[ZIN] = 1'b1; end
          [5'd3:5'd10]:  begin c[GRC] = 1'b1; c[ROUT] = 1'b1; c[ZIN] = 1'b1; c[40:ALU_LO] = alu; end
          [5'd11:5'd13]: begin c[COUT] = 1'b1; c[ZIN] = 1'b1; c[40:ALU_LO] = alu; end
`ifdef MULDIV_EN
          5'd14, 5'd15: begin c[GRB] = 1'b1; c[ROUT] = 1'b1; c[START] = 1'b1; c[40:ALU_LO] = alu; nxt = WAIT_ALU; end
`endif
          5'd16, 5'd17: begin c[ZLOWOUT] = 1'b1; c[GRA] = 1'b1; c[RIN] = 1'b1; last = 1'b1; end
          5'd18: begin c[PCOUT] = 1'b1; c[YIN] = 1'b1; end
          default: nxt = T0;
        endcase
      end
      T5: begin
        nxt = T6;
        case (op) inside
          5'd0, 5'd2: begin c[ZLOWOUT] = 1'b1; c[MARIN] = 1'b1; end
          5'd1, [5'd3:5'd13]: begin c[ZLOWOUT] = 1'b1; c[GRA] = 1'b1; c[RIN] = 1'b1; last = 1'b1; end
`ifdef MULDIV_EN
          5'd14, 5'd15: begin c[ZLOWOUT] = 1'b1; c[LOIN] = 1'b1; end
`endif
          5'd18: begin c[COUT] = 1'b1; c[ALU_LO] = 1'b1; c[ZIN] = 1'b1; end
          default: nxt = T0;
        endcase
      end
      T6: begin
        nxt = T7;
        case (op) inside
          5'd0: begin c[READ] = 1'b1; c[MDRIN] = 1'b1; end
          5'd2: begin c[GRA] = 1'b1; c[ROUT] = 1'b1; c[MDRIN] = 1'b1; end
`ifdef MULDIV_EN
          5'd14, 5'd15: begin c[ZHIGHOUT] = 1'b1; c[HIIN] = 1'b1; last = 1'b1; end
`endif
          5'd18: begin c[ZLOWOUT] = 1'b1; c[BRANCH] = 1'b1; c[PCIN] = do_branch; last = 1'b1; end
          default: nxt = T0;
        endcase
      end
      T7: begin
        last = 1'b1;
        c[MDROUT] = (op == 5'd0);
        c[GRA] = (op == 5'd0);
        c[RIN] = (op == 5'd0);
        c[WRITE] = (op == 5'd2);
      end
`ifdef MULDIV_EN
      WAIT_ALU: begin
        c[GRB] = 1'b1;
        c[ROUT] = 1'b1;
        c[40:ALU_LO] = alu;
        c[ZIN] = alu_done;
        nxt = alu_done ? T5 : WAIT_ALU;
      end
`endif
      HALT: begin halted = 1'b1; nxt = (run && !stop) ? T0 : HALT; end
      default: nxt = T0;
    endcase
    if (last) nxt = (stop || (state == T3 && op == 5'd26)) ? HALT : T0;
  end
  assign instr_done = last;
  assign ctl = CTL_W'(c);
  always_ff @(posedge clk) state <= reset ? RST : nxt;
endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL provide parameter CTL_W, default 41, meaning width of the packed control word.
REQ-002 SHALL provide parameter OP_W, default 5, meaning opcode width (IR[31:27]).
REQ-003 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 SHALL have port ir_op  input  OP_W  opcode field of the instruction register, valid from step T3.
REQ-006 SHALL have port do_branch  input  1  branch-condition result from the CON flip-flop logic.
REQ-007 SHALL have port alu_done  input  1  multi-cycle ALU (MUL/DIV) result-ready pulse.
REQ-008 SHALL have port stop  input  1  request halt at the next instruction boundary.
REQ-009 SHALL have port run  input  1  leave HALT and resume fetching.
REQ-010 SHALL have port ctl  output  CTL_W  packed datapath control word for the current step.
REQ-011 SHALL have port halted  output  1  high while in HALT.
REQ-012 SHALL have port illegal  output  1  one-cycle pulse on an undefined opcode.
REQ-013 SHALL have port instr_done  output  1  one-cycle pulse during the last step of every instruction.

Function
REQ-014 ctl bit map SHALL be: 0 PCout,1 PCin,2 IncPC,3 MARin,4 Read,5 MDRin,6 MDRout,7 IRin,8 Zin,9 Zlowout,10 Zhighout,11 Yin,12 Gra,13 Grb,14 Grc,15 Rin,16 Rout,17 BAout,18 Cout,19 Write,20 LOin,21 LOout,22 HIin,23 HIout,24 CONin,25 Branch,26 OUTin,27 INout,28 start,29-40 ADD,SUB,MUL,DIV,SHR,SHL,ROR,ROL,AND,OR,NEG,NOT.
REQ-015 States SHALL be RST, T0..T7, WAIT_ALU, HALT; state registered, ctl a combinational decode of state and ir_op; unlisted bits are 0.
REQ-016 Fetch: T0 PCout,MARin,IncPC,Zin; T1 Zlowout,PCin,Read,MDRin; T2 MDRout,IRin; T2->T3 unconditionally.
REQ-017 Opcodes 3-10 (add,sub,and,or,shr,shl,ror,rol): T3 Grb,Rout,Yin; T4 Grc,Rout,op,Zin; T5 Zlowout,Gra,Rin.
REQ-018 Opcodes 11-13 (addi,andi,ori): as REQ-017 but T4 uses Cout in place of Grc,Rout.
REQ-019 ld (0): T3 Grb,BAout,Yin; T4 Cout,ADD,Zin; T5 Zlowout,MARin; T6 Read,MDRin; T7 MDRout,Gra,Rin.
REQ-020 ldi (1): T3-T4 as ld; T5 Zlowout,Gra,Rin. st (2): T3-T5 as ld; T6 Gra,Rout,MDRin; T7 Write.
REQ-021 neg/not (16,17): T3 Grb,Rout,op,Zin; T4 Zlowout,Gra,Rin.
REQ-022 br (18): T3 Gra,Rout,CONin; T4 PCout,Yin; T5 Cout,ADD,Zin; T6 Zlowout,Branch (PC loads only if do_branch).
REQ-023 jr (19) T3 Gra,Rout,PCin; in (21) T3 INout,Gra,Rin; out (22) T3 Gra,Rout,OUTin; mfhi (23) T3 HIout,Gra,Rin; mflo (24) T3 LOout,Gra,Rin; nop (25) T3 only, ctl=0.
REQ-024 halt (26): T3 ctl=0, then HALT; HALT holds ctl=0 until run=1, then T0.
REQ-025 Opcodes 27-31 SHALL execute as nop and pulse illegal in T3.
REQ-026 instr_done SHALL pulse in the final step; next state T0, or HALT if stop=1 in that cycle.
REQ-027 run and stop both 1 in HALT: stay in HALT. run outside HALT: ignored.

Reset
REQ-028 reset=1 SHALL force state RST next edge from any state, abandoning the instruction, including WAIT_ALU.
REQ-029 In RST ctl, halted, illegal, instr_done SHALL all be 0; RST->T0 on the first edge with reset=0.

Configuration
REQ-030 With MULDIV_EN defined, mul (14)/div (15): T3 Gra,Rout,Yin; T4 Grb,Rout,op,start; WAIT_ALU Grb,Rout,op held, Zin asserted when alu_done=1, then T5 Zlowout,LOin; T6 Zhighout,HIin; WAIT_ALU has no timeout.
REQ-031 Without MULDIV_EN, opcodes 14/15 SHALL be treated as illegal per REQ-025 and WAIT_ALU SHALL not exist.

Verification
REQ-032 reset for 2 cycles then release -> ctl=0 in RST, T0 ctl has bits 0,2,3,8 set, T2 bit 7, T3 next.
REQ-033 ir_op=3 -> T4 ctl bits 14,16,8,29 set; instr_done in T5; 6 cycles fetch-to-fetch.
REQ-034 ir_op=18, do_branch=0 and =1 -> Branch (bit 25) high in T6 both cases; T0 follows.
REQ-035 ir_op=14 with MULDIV_EN, alu_done after 32 cycles -> ctl held in WAIT_ALU, Zin only on alu_done cycle, LOin then HIin; without macro illegal pulses in T3.
REQ-036 ir_op=26 -> halted=1 indefinitely; run=1 -> T0 next cycle; stop=1 during ld T7 -> HALT after T7.
REQ-037 reset asserted in ld T6 -> RST next cycle, Read/MDRin deasserted, no Gra/Rin step issued.
